// File: rtl/shading_pixel_writer_if.sv
// Shading pixel writer bus: shading results in, framebuffer write requests out.
// The slave modport is the pixel writer; the master modport is the environment
// driving pixels, frame control and write acceptance.
interface shading_pixel_writer_if #(
  parameter int ADDR_W = 32
);
  logic                    i_start;
  logic [ADDR_W-1:0]       i_fb_base;
  logic [0:2][31:0]        i_light;      // [0]=R [1]=G [2]=B, signed 16.16
  logic                    i_valid;
  logic                    o_busy;
  logic [ADDR_W-1:0]       o_wr_addr;
  logic [31:0]             o_wr_data;
  logic                    o_wr_valid;
  logic                    i_wr_ready;
  logic                    o_frame_done;

  modport slave (
    input  i_start, i_fb_base, i_light, i_valid, i_wr_ready,
    output o_busy, o_wr_addr, o_wr_data, o_wr_valid, o_frame_done
  );

  modport master (
    output i_start, i_fb_base, i_light, i_valid, i_wr_ready,
    input  o_busy, o_wr_addr, o_wr_data, o_wr_valid, o_frame_done
  );
endinterface

// File: rtl/shading_pixel_writer.sv
// Shading pixel writer: converts 16.16 RGB shading results to 8-bit pixels,
// buffers them with their byte addresses in a small FIFO and issues framebuffer
// writes with valid/ready backpressure, pulsing o_frame_done after the last write.
// Optional feature macro: SHADING_PIXEL_CLAMP_EN (negative components -> 8'h00).
module shading_pixel_writer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  shading_pixel_writer_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int X_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } entry_t;

  state_t            state, next_state;
  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] base_q, offset_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              done_q;

  logic   busy, accept, pop, empty, last_pix, start_acc, done_d;
  entry_t push_entry;

  // Convert one 16.16 component to an 8-bit channel (saturate at 1.0, truncate below).
  function automatic logic [7:0] to_byte(input logic [31:0] c);
`ifdef SHADING_PIXEL_CLAMP_EN
    if (c[31]) return 8'h00;
`endif
    if (c >= 32'h0001_0000) return 8'hFF;
    return c[15:8];
  endfunction

  assign empty     = (count == '0);
  assign busy      = (state != RUN) || (count == CNT_W'(FIFO_DEPTH));
  assign accept    = bus.i_valid && !busy;
  assign pop       = !empty && bus.i_wr_ready;
  assign start_acc = (state == IDLE) && bus.i_start;
  assign last_pix  = (x_q == X_W'(WIDTH - 1)) && (y_q == Y_W'(HEIGHT - 1));

  assign push_entry.addr = base_q + offset_q;
  assign push_entry.data = {8'h00, to_byte(bus.i_light[0]),
                            to_byte(bus.i_light[1]), to_byte(bus.i_light[2])};

  // Head of FIFO drives the write port; forced to zero while nothing is pending.
  assign bus.o_busy       = busy;
  assign bus.o_wr_valid   = !empty;
  assign bus.o_wr_addr    = empty ? '0 : mem[rd_ptr].addr;
  assign bus.o_wr_data    = empty ? '0 : mem[rd_ptr].data;
  assign bus.o_frame_done = done_q;

  // Next-state logic and end-of-frame detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    done_d     = 1'b0;
    case (state)
      IDLE:    if (bus.i_start) next_state = RUN;
      RUN:     if (accept && last_pix) next_state = DRAIN;
      DRAIN: begin
        if (empty) begin
          next_state = IDLE;
        end else if (pop && (count == CNT_W'(1))) begin
          next_state = IDLE;
          done_d     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and frame-done pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!i_rstn) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= done_d;
    end
  end

  // Raster position, byte offset and latched base; restarted by every accepted i_start.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      base_q   <= '0;
      offset_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (start_acc) begin
      base_q   <= bus.i_fb_base;
      offset_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (accept) begin
      offset_q <= offset_q + ADDR_W'(4);
      if (x_q == X_W'(WIDTH - 1)) begin
        x_q <= '0;
        y_q <= y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; entries are only visible through the occupancy count, which is.
    if (accept) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_shading_pixel_writer.sv
// Self-checking bench for shading_pixel_writer (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4).
// A queue-based reference model predicts busy, write requests and frame-done.
module tb_shading_pixel_writer;

  localparam int W = 4, H = 2, D = 4, TOTAL = W * H;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  shading_pixel_writer_if #(.ADDR_W(32)) bus ();

  shading_pixel_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .ADDR_W(32)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  int passed = 0, total = 0, done_seen = 0;

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
  mode_t       mode;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] m_base;
  int          m_idx;
  bit          m_done;

  function automatic logic [7:0] ref_conv(input logic [31:0] c);
    longint v;
    v = longint'(c);
`ifdef SHADING_PIXEL_CLAMP_EN
    if ($signed(c) < 0) return 8'h00;
`endif
    if (v >= 65536) return 8'd255;
    return 8'((v / 256) % 256);
  endfunction

  function automatic logic [31:0] rand_comp();
    case ($urandom % 4)
      0:       return 32'($urandom % 65536);
      1:       return 32'($urandom % 131072);
      2:       return $urandom;
      default: return ($urandom % 2) ? 32'h0000_FFFF : 32'h0001_0000;
    endcase
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    exp_addr_q.delete();
    exp_data_q.delete();
    m_base = '0;
    m_idx  = 0;
    m_done = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.i_start    = 1'b0;
    bus.i_fb_base  = '0;
    bus.i_valid    = 1'b0;
    bus.i_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus.i_light[i] = '0;
  endtask

  task automatic rand_light();
    for (int i = 0; i < 3; i++) bus.i_light[i] = rand_comp();
  endtask

  // One clock: compare outputs with the model, then advance model across the edge.
  task automatic cycle();
    bit exp_busy, exp_valid, pop, push, st;
    logic [31:0] pd;
    #1;
    exp_valid = (exp_addr_q.size() != 0);
    exp_busy  = (mode != M_RUN) || (exp_addr_q.size() == D);
    total++;
    if (bus.o_busy !== exp_busy) $display("FAIL busy: got %b want %b @%0t", bus.o_busy, exp_busy, $time);
    else passed++;
    total++;
    if (bus.o_wr_valid !== exp_valid) $display("FAIL wr_valid: got %b want %b @%0t", bus.o_wr_valid, exp_valid, $time);
    else passed++;
    total++;
    if (bus.o_frame_done !== m_done) $display("FAIL frame_done: got %b want %b @%0t", bus.o_frame_done, m_done, $time);
    else passed++;
    if (bus.o_frame_done === 1'b1) done_seen++;
    if (exp_valid) begin
      total++;
      if (bus.o_wr_addr !== exp_addr_q[0]) $display("FAIL wr_addr: got %h want %h @%0t", bus.o_wr_addr, exp_addr_q[0], $time);
      else passed++;
      total++;
      if (bus.o_wr_data !== exp_data_q[0]) $display("FAIL wr_data: got %h want %h @%0t", bus.o_wr_data, exp_data_q[0], $time);
      else passed++;
    end
    pop  = exp_valid && (bus.i_wr_ready === 1'b1);
    push = (bus.i_valid === 1'b1) && !exp_busy;
    st   = (mode == M_IDLE) && (bus.i_start === 1'b1);
    pd   = {8'h00, ref_conv(bus.i_light[0]), ref_conv(bus.i_light[1]), ref_conv(bus.i_light[2])};
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (pop) begin
      void'(exp_addr_q.pop_front());
      void'(exp_data_q.pop_front());
      if (mode == M_DRAIN && exp_addr_q.size() == 0) begin
        mode   = M_IDLE;
        m_done = 1'b1;
      end
    end
    if (push) begin
      exp_addr_q.push_back(m_base + 32'(4 * m_idx));
      exp_data_q.push_back(pd);
      m_idx++;
      if (m_idx == TOTAL) mode = M_DRAIN;
    end
    if (st) begin
      mode   = M_RUN;
      m_base = bus.i_fb_base;
      m_idx  = 0;
    end
  endtask

  // Drain with ready high until the model returns to idle, then check one done pulse.
  task automatic finish_frame(input int done_before);
    int n = 0;
    bus.i_start    = 1'b0;
    bus.i_wr_ready = 1'b1;
    while (mode != M_IDLE && n < 200) begin
      cycle();
      n++;
    end
    total++;
    if (mode != M_IDLE) $display("FAIL drain_timeout: frame not finished after %0d cycles", n);
    else passed++;
    bus.i_valid = 1'b1;   // ignored in IDLE
    cycle();
    cycle();
    bus.i_valid = 1'b0;
    total++;
    if (done_seen - done_before !== 1) $display("FAIL done_count: got %0d want 1", done_seen - done_before);
    else passed++;
  endtask

  task automatic start_frame(input logic [31:0] base);
    bus.i_fb_base = base;
    bus.i_start   = 1'b1;
    cycle();
    bus.i_start   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    #2;
    total++; if (bus.o_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.o_busy); else passed++;
    total++; if (bus.o_wr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_wr_valid); else passed++;
    total++; if (bus.o_wr_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.o_wr_addr); else passed++;
    total++; if (bus.o_wr_data !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.o_wr_data); else passed++;
    total++; if (bus.o_frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.o_frame_done); else passed++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycle();
  endtask

  task automatic test_conversion();
    logic [7:0] exp_r;
    int d0 = done_seen;
`ifdef SHADING_PIXEL_CLAMP_EN
    exp_r = 8'h00;
`else
    exp_r = 8'hFF;
`endif
    start_frame(32'h1000);
    bus.i_wr_ready = 1'b1;
    bus.i_valid    = 1'b1;
    bus.i_light[0] = 32'h0000_8000; bus.i_light[1] = 32'h0000_4000; bus.i_light[2] = 32'h0000_FFFF;
    cycle();
    bus.i_light[0] = 32'h0001_0000; bus.i_light[1] = 32'h7FFF_FFFF; bus.i_light[2] = 32'h0;
    #1;
    total++; if (bus.o_wr_addr !== 32'h1000) $display("FAIL px0_addr: got %h want 00001000", bus.o_wr_addr); else passed++;
    total++; if (bus.o_wr_data !== 32'h0080_40FF) $display("FAIL px0_data: got %h want 008040ff", bus.o_wr_data); else passed++;
    cycle();
    bus.i_light[0] = 32'hFFFF_FFFF; bus.i_light[1] = 32'h0000_1234; bus.i_light[2] = 32'h0000_00FF;
    #1;
    total++; if (bus.o_wr_data !== 32'h00FF_FF00) $display("FAIL px1_data: got %h want 00ffff00", bus.o_wr_data); else passed++;
    cycle();
    bus.i_valid = 1'b0;
    #1;
    total++; if (bus.o_wr_data !== {8'h00, exp_r, 8'h12, 8'h00}) $display("FAIL px2_neg: got %h want %h", bus.o_wr_data, {8'h00, exp_r, 8'h12, 8'h00}); else passed++;
    bus.i_valid = 1'b1;
    while (m_idx < TOTAL) begin
      rand_light();
      cycle();
    end
    bus.i_valid = 1'b0;
    finish_frame(d0);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int d0 = done_seen;
    int n  = 0;
    start_frame(32'h1000);
    bus.i_wr_ready = 1'b0;
    bus.i_valid    = 1'b1;
    rand_light();
    cycle();
    held = bus.o_wr_data;
    for (int i = 0; i < 7; i++) begin
      rand_light();
      cycle();
    end
    total++; if (bus.o_busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", bus.o_busy); else passed++;
    total++; if (bus.o_wr_addr !== 32'h1000) $display("FAIL bp_addr_hold: got %h want 00001000", bus.o_wr_addr); else passed++;
    total++; if (bus.o_wr_data !== held) $display("FAIL bp_data_hold: got %h want %h", bus.o_wr_data, held); else passed++;
    bus.i_wr_ready = 1'b1;
    while (m_idx < TOTAL && n < 100) begin
      rand_light();
      cycle();
      n++;
    end
    bus.i_valid = 1'b0;
    finish_frame(d0);
  endtask

  task automatic test_random_frame(input int iter);
    int d0 = done_seen;
    int n  = 0;
    start_frame($urandom & 32'hFFFF_FFFC);
    while (mode != M_IDLE && n < 400) begin
      bus.i_valid    = ($urandom % 3) != 0;
      bus.i_wr_ready = ($urandom % 3) != 0;
      bus.i_start    = ($urandom % 4) == 0;   // ignored outside IDLE
      bus.i_fb_base  = $urandom;
      rand_light();
      cycle();
      n++;
    end
    bus.i_valid = 1'b0;
    total++;
    if (mode != M_IDLE) $display("FAIL random_timeout: iteration %0d did not finish", iter);
    else passed++;
    bus.i_start = 1'b0;
    cycle();
    total++;
    if (done_seen - d0 !== 1) $display("FAIL random_done_count: iteration %0d got %0d want 1", iter, done_seen - d0);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int d0;
    start_frame(32'h3000);
    bus.i_wr_ready = 1'b0;
    bus.i_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_light();
      cycle();
    end
    bus.i_valid = 1'b0;
    cycle();
    total++; if (bus.o_wr_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", bus.o_wr_valid); else passed++;
    d0   = done_seen;
    rstn = 1'b0;
    #1;
    total++; if (bus.o_wr_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", bus.o_wr_valid); else passed++;
    total++; if (bus.o_busy !== 1'b1) $display("FAIL mid_reset_busy: got %b want 1", bus.o_busy); else passed++;
    model_reset();
    bus.i_wr_ready = 1'b1;
    cycle();
    rstn = 1'b1;
    cycle();
    cycle();
    total++; if (done_seen !== d0) $display("FAIL reset_no_done: got %0d pulses want 0", done_seen - d0); else passed++;
    start_frame(32'h4000);
    bus.i_valid = 1'b1;
    rand_light();
    cycle();
    bus.i_valid = 1'b0;
    #1;
    total++; if (bus.o_wr_addr !== 32'h4000) $display("FAIL restart_addr: got %h want 00004000", bus.o_wr_addr); else passed++;
    cycle();
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_backpressure();
    for (int i = 0; i < 6; i++) test_random_frame(i);
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
